// File: rtl/instruction_loader_pkg.sv
// Shared types and default widths for the instruction loader.
package instruction_loader_pkg;

  localparam int unsigned DefWordSize  = 32;
  localparam int unsigned DefAddrWidth = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/instruction_loader_fsm.sv
// Load sequencing: state, remaining-word counter, and the Busy/Loaded/InReady flags.
module loader_fsm
  import instruction_loader_pkg::*;
#(
  parameter int unsigned AddrWidth = DefAddrWidth
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [AddrWidth-1:0] i_count,
  input  logic                 i_accept,
  output logic                 o_load_start,
  output logic                 o_in_ready,
  output logic                 o_busy,
  output logic                 o_loaded
);

  state_t               r_state, w_state_next;
  logic [AddrWidth-1:0] r_remaining, w_remaining_next;
  logic                 r_loaded, w_loaded_next;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_remaining <= '0;
      r_loaded    <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_remaining <= w_remaining_next;
      r_loaded    <= w_loaded_next;
    end
  end

  always_comb begin
    w_state_next     = r_state;
    w_remaining_next = r_remaining;
    w_loaded_next    = r_loaded;
    o_load_start     = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_start) begin
          if (i_count != '0) begin
            o_load_start     = 1'b1;
            w_state_next     = ST_LOAD;
            w_remaining_next = i_count;
            w_loaded_next    = 1'b0;
          end else begin
            // An empty program completes immediately without touching memory.
            w_loaded_next = 1'b1;
          end
        end
      end
      ST_LOAD: begin
        if (i_accept) begin
          w_remaining_next = r_remaining - AddrWidth'(1);
          if (r_remaining == AddrWidth'(1)) begin
            w_state_next = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        w_state_next  = ST_IDLE;
        w_loaded_next = 1'b1;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  assign o_in_ready = (r_state == ST_LOAD);
  assign o_busy     = (r_state != ST_IDLE);
  assign o_loaded   = r_loaded;

endmodule

// File: rtl/instruction_loader.sv
// Streams a program into instruction memory, then returns the address port to fetch.
module instruction_loader
  import instruction_loader_pkg::*;
#(
  parameter int unsigned WordSize     = DefWordSize,
  parameter int unsigned AddrWidth    = DefAddrWidth,
  parameter int unsigned StartAddress = 0
) (
  input  logic                 Clock,
  input  logic                 ResetN,
  input  logic                 Start,
  input  logic [AddrWidth-1:0] Count,
  input  logic                 InValid,
  input  logic [WordSize-1:0]  InData,
  output logic                 InReady,
  input  logic [63:0]          FetchAddress,
  output logic                 MemWrite,
  output logic [AddrWidth-1:0] MemAddress,
  output logic [WordSize-1:0]  MemData,
  output logic                 Busy,
  output logic                 Loaded
);

  logic                 w_load_start;
  logic                 w_in_ready;
  logic                 w_busy;
  logic                 w_accept;
  logic                 w_unused_fetch;
  logic [AddrWidth-1:0] r_wr_ptr;
  logic [AddrWidth-1:0] r_wr_addr;
  logic                 r_mem_write;
  logic [WordSize-1:0]  r_mem_data;

  loader_fsm #(
    .AddrWidth(AddrWidth)
  ) u_fsm (
    .i_clk       (Clock),
    .i_rst_n     (ResetN),
    .i_start     (Start),
    .i_count     (Count),
    .i_accept    (w_accept),
    .o_load_start(w_load_start),
    .o_in_ready  (w_in_ready),
    .o_busy      (w_busy),
    .o_loaded    (Loaded)
  );

  assign w_accept = InValid & w_in_ready;

  always_ff @(posedge Clock or negedge ResetN) begin
    if (!ResetN) begin
      r_wr_ptr    <= '0;
      r_wr_addr   <= '0;
      r_mem_write <= 1'b0;
      r_mem_data  <= '0;
    end else begin
      r_mem_write <= w_accept;
      if (w_load_start) begin
        r_wr_ptr <= AddrWidth'(StartAddress);
      end
      if (w_accept) begin
        r_wr_addr  <= r_wr_ptr;
        r_mem_data <= InData;
        r_wr_ptr   <= r_wr_ptr + AddrWidth'(1);
      end
    end
  end

  // Only the low word-address bits reach the memory; the rest of the fetch address is dropped.
  assign w_unused_fetch = ^FetchAddress[63:AddrWidth];

  assign MemAddress = w_busy ? r_wr_addr : FetchAddress[AddrWidth-1:0];
  assign MemWrite   = r_mem_write;
  assign MemData    = r_mem_data;
  assign InReady    = w_in_ready;
  assign Busy       = w_busy;

endmodule

// File: tb/tb_instruction_loader.sv
// Directed self-checking bench for instruction_loader.
module tb_instruction_loader;

  logic        Clock = 1'b0;
  logic        ResetN;
  logic        Start, Start2;
  logic [15:0] Count;
  logic        InValid;
  logic [31:0] InData;
  logic [63:0] FetchAddress;

  logic        InReady, MemWrite, Busy, Loaded;
  logic [15:0] MemAddress;
  logic [31:0] MemData;

  logic        u2_InReady, u2_MemWrite, u2_Busy, u2_Loaded;
  logic [15:0] u2_MemAddress;
  logic [31:0] u2_MemData;

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  logic [31:0] mem [0:15];
  logic [31:0] prog [0:2];

  always #5 Clock = ~Clock;

  // Behavioural instruction store fed by the primary loader.
  always @(posedge Clock) begin
    if (MemWrite) mem[MemAddress[3:0]] <= MemData;
  end

  instruction_loader dut (
    .Clock(Clock), .ResetN(ResetN), .Start(Start), .Count(Count),
    .InValid(InValid), .InData(InData), .InReady(InReady),
    .FetchAddress(FetchAddress), .MemWrite(MemWrite), .MemAddress(MemAddress),
    .MemData(MemData), .Busy(Busy), .Loaded(Loaded)
  );

  instruction_loader #(.StartAddress(32'hFFFE)) dut_wrap (
    .Clock(Clock), .ResetN(ResetN), .Start(Start2), .Count(Count),
    .InValid(InValid), .InData(InData), .InReady(u2_InReady),
    .FetchAddress(FetchAddress), .MemWrite(u2_MemWrite), .MemAddress(u2_MemAddress),
    .MemData(u2_MemData), .Busy(u2_Busy), .Loaded(u2_Loaded)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    prog[0] = 32'h015A04B3;
    prog[1] = 32'h40538333;
    prog[2] = 32'h00F6F1B3;
    ResetN = 1'b0; Start = 1'b0; Start2 = 1'b0; Count = '0;
    InValid = 1'b0; InData = '0; FetchAddress = '0;

    #12;
    chk("rst_inready", InReady, 0);
    chk("rst_memwrite", MemWrite, 0);
    chk("rst_memdata", MemData, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_loaded", Loaded, 0);
    chk("rst_memaddr", MemAddress, 0);
    FetchAddress = 64'd7;
    #1 chk("idle_fetch_mux", MemAddress, 7);
    tick();
    ResetN = 1'b1;

    // Three words back-to-back
    Start = 1'b1; Count = 16'd3; InValid = 1'b1; InData = prog[0];
    tick();
    chk("t1_inready", InReady, 1);
    chk("t1_busy", Busy, 1);
    chk("t1_nowrite", MemWrite, 0);
    Start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t1_wr", MemWrite, 1);
      chk("t1_addr", MemAddress, i);
      chk("t1_data", MemData, prog[i]);
      if (i < 2) InData = prog[i+1];
    end
    chk("t1_drain_inready", InReady, 0);
    chk("t1_drain_busy", Busy, 1);
    InValid = 1'b0;
    tick();
    chk("t1_loaded", Loaded, 1);
    chk("t1_busy_done", Busy, 0);
    chk("t1_wr_done", MemWrite, 0);
    for (int i = 0; i < 3; i++) begin
      FetchAddress = 64'(i);
      #1;
      chk("t1_rb_addr", MemAddress, i);
      chk("t1_rb_data", mem[MemAddress[3:0]], prog[i]);
    end

    // Two words with a three-cycle InValid gap
    Start = 1'b1; Count = 16'd2; InValid = 1'b1; InData = 32'h11111111;
    tick();
    chk("t2_loaded_cleared", Loaded, 0);
    Start = 1'b0;
    tick();
    chk("t2_wr0", MemWrite, 1);
    chk("t2_addr0", MemAddress, 0);
    InValid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t2_gap_wr", MemWrite, 0);
      chk("t2_gap_ready", InReady, 1);
    end
    InValid = 1'b1; InData = 32'h22222222;
    tick();
    chk("t2_wr1", MemWrite, 1);
    chk("t2_addr1", MemAddress, 1);
    chk("t2_data1", MemData, 32'h22222222);
    chk("t2_not_loaded", Loaded, 0);
    InValid = 1'b0;
    tick();
    chk("t2_loaded", Loaded, 1);
    chk("t2_wr_done", MemWrite, 0);
    FetchAddress = 64'd0; #1 chk("t2_rb0", mem[MemAddress[3:0]], 32'h11111111);
    FetchAddress = 64'd1; #1 chk("t2_rb1", mem[MemAddress[3:0]], 32'h22222222);
    FetchAddress = 64'd2; #1 chk("t2_rb2_untouched", mem[MemAddress[3:0]], prog[2]);

    // Address wrap from 0xFFFE
    Start2 = 1'b1; Count = 16'd3; InValid = 1'b1; InData = 32'hA0A0A0A0;
    tick();
    Start2 = 1'b0;
    chk("t3_inready", u2_InReady, 1);
    chk("t3_other_idle", InReady, 0);
    tick();
    chk("t3_wr0", u2_MemWrite, 1);
    chk("t3_addr0", u2_MemAddress, 16'hFFFE);
    InData = 32'hB0B0B0B0;
    tick();
    chk("t3_addr1", u2_MemAddress, 16'hFFFF);
    InData = 32'hC0C0C0C0;
    tick();
    chk("t3_addr2", u2_MemAddress, 16'h0000);
    chk("t3_data2", u2_MemData, 32'hC0C0C0C0);
    InValid = 1'b0;
    FetchAddress = 64'h0001_0000_0000_0003;
    tick();
    chk("t3_loaded", u2_Loaded, 1);
    chk("t3_fetch_slice", u2_MemAddress, 16'h0003);

    // Start re-pulsed during LOAD must be ignored
    Start = 1'b1; Count = 16'd4; InValid = 1'b1; InData = 32'hD0000000;
    tick();
    Count = 16'd2;
    tick();
    chk("t4_addr0", MemAddress, 0);
    Start = 1'b0;
    for (int i = 1; i < 4; i++) begin
      InData = 32'hD0000000 + 32'(i);
      tick();
      chk("t4_wr", MemWrite, 1);
      chk("t4_addr", MemAddress, i);
      chk("t4_data", MemData, 32'hD0000000 + 32'(i));
    end
    chk("t4_drain", InReady, 0);
    InValid = 1'b0;
    tick();
    chk("t4_loaded", Loaded, 1);

    // Asynchronous reset after two of four accepts
    Start = 1'b1; Count = 16'd4; InValid = 1'b1; InData = 32'hE0E0E0E0;
    tick();
    Start = 1'b0;
    tick();
    chk("t5_addr0", MemAddress, 0);
    InData = 32'hE1E1E1E1;
    tick();
    chk("t5_addr1", MemAddress, 1);
    #2;
    ResetN = 1'b0;
    FetchAddress = 64'd5;
    #1;
    chk("t5_inready", InReady, 0);
    chk("t5_memwrite", MemWrite, 0);
    chk("t5_memdata", MemData, 0);
    chk("t5_busy", Busy, 0);
    chk("t5_loaded", Loaded, 0);
    chk("t5_memaddr", MemAddress, 5);
    InValid = 1'b0;
    tick();
    ResetN = 1'b1;

    // Empty program
    Start = 1'b1; Count = 16'd0; InValid = 1'b1;
    tick();
    chk("t6_loaded", Loaded, 1);
    chk("t6_inready", InReady, 0);
    chk("t6_busy", Busy, 0);
    Start = 1'b0;
    tick();
    chk("t6_inready2", InReady, 0);
    chk("t6_memwrite", MemWrite, 0);
    InValid = 1'b0;

    // Restart after the aborted load begins again at address 0
    Start = 1'b1; Count = 16'd1; InValid = 1'b1; InData = 32'hF00DCAFE;
    tick();
    chk("t7_loaded_cleared", Loaded, 0);
    chk("t7_inready", InReady, 1);
    Start = 1'b0;
    tick();
    chk("t7_wr", MemWrite, 1);
    chk("t7_addr", MemAddress, 0);
    chk("t7_drain", InReady, 0);
    InValid = 1'b0;
    tick();
    chk("t7_loaded", Loaded, 1);
    FetchAddress = 64'd0;
    #1 chk("t7_rb", mem[MemAddress[3:0]], 32'hF00DCAFE);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
